ofdm_preamble_seq: RTL

Frame-level sequencer that drives the OFDM preamble ROM and splices its samples ahead of the payload sample stream. On `start` it reads the ROM `PREAMBLE_REPEAT` times over addresses 0..`PREAMBLE_LEN`-1, then forwards payload I/Q samples until `s_last`. Output is a single valid/ready I/Q stream feeding the IFFT/DAC path. All backpressure is honoured, including stalling the ROM through its `en` pin.

---
 rtl/ofdm_preamble_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ofdm_preamble_seq.sv
// rtl/ofdm_preamble_seq.sv - OFDM preamble sequencer: ROM preamble copies spliced ahead of payload I/Q
// Preamble beats pass ROM outputs straight through; payload beats go through a one-deep register.
module ofdm_preamble_seq #(
    parameter int PREAMBLE_LEN    = 256,
    parameter int PREAMBLE_REPEAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rom_addr,
    output logic        rom_en,
    input  logic [15:0] rom_i,
    input  logic [15:0] rom_q,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_i,
    input  logic [15:0] s_q,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_i,
    output logic [15:0] m_q,
    output logic        m_sof,
    output logic        m_pre,
    output logic        m_last
);

    localparam logic [11:0] TOTAL_READS = 12'(PREAMBLE_LEN * PREAMBLE_REPEAT);
    localparam logic [7:0]  LAST_ADDR   = 8'(PREAMBLE_LEN - 1);
    localparam logic [3:0]  REPEATS     = 4'(PREAMBLE_REPEAT);

    typedef enum logic [1:0] {IDLE, PRE, PAY} state_t;

    state_t      state;
    logic [11:0] rd_cnt;
    logic [3:0]  rep_cnt;
    logic [15:0] pay_i;
    logic [15:0] pay_q;
    logic        got_last;
    logic        m_hs;

    assign m_hs    = m_valid && m_ready;
    assign busy    = (state != IDLE);
    // A read may only be issued when the output slot is free or draining this cycle.
    assign rom_en  = (state == PRE) && (rd_cnt < TOTAL_READS) && (!m_valid || m_ready);
    assign s_ready = (state == PAY) && !got_last && (!m_valid || m_ready);
    assign m_i     = m_pre ? rom_i : pay_i;
    assign m_q     = m_pre ? rom_q : pay_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            done     <= 1'b0;
            rom_addr <= 8'd0;
            rd_cnt   <= 12'd0;
            rep_cnt  <= 4'd0;
            pay_i    <= 16'd0;
            pay_q    <= 16'd0;
            got_last <= 1'b0;
            m_valid  <= 1'b0;
            m_sof    <= 1'b0;
            m_pre    <= 1'b0;
            m_last   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= PRE;
                        rom_addr <= 8'd0;
                        rd_cnt   <= 12'd0;
                        rep_cnt  <= 4'd0;
                        got_last <= 1'b0;
                    end
                end
                PRE: begin
                    if (rom_en) begin
                        rd_cnt  <= rd_cnt + 12'd1;
                        m_valid <= 1'b1;
                        m_pre   <= 1'b1;
                        m_sof   <= (rd_cnt == 12'd0);
                        if (rom_addr == LAST_ADDR) begin
                            rom_addr <= 8'd0;
                            rep_cnt  <= rep_cnt + 4'd1;
                        end else begin
                            rom_addr <= rom_addr + 8'd1;
                        end
                    end else if (m_hs) begin
                        m_valid <= 1'b0;
                        m_sof   <= 1'b0;
                        // Once every copy has been read, any drained beat is the final preamble beat.
                        if (rep_cnt == REPEATS) begin
                            state <= PAY;
                            m_pre <= 1'b0;
                        end
                    end
                end
                PAY: begin
                    if (s_valid && s_ready) begin
                        pay_i    <= s_i;
                        pay_q    <= s_q;
                        m_last   <= s_last;
                        m_valid  <= 1'b1;
                        got_last <= s_last;
                    end else if (m_hs) begin
                        m_valid <= 1'b0;
                        if (m_last) begin
                            m_last <= 1'b0;
                            state  <= IDLE;
                            done   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
